// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the rv32i 5-stage pipeline controller.
//   - stage indices (fetch..commit)
//   - controller state encoding
//   - per-event register-enable / bubble patterns
//   - hazard event enumeration
//   - advance_valid(): moves the per-stage valid bits for a given pen/bubble
package pipe_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_C = 4;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [4:0] PEN_NONE        = 5'b00000;
  localparam logic [4:0] PEN_ALL         = 5'b11111;
  localparam logic [4:0] PEN_TRAP        = 5'b10000;
  localparam logic [4:0] PEN_LOAD_USE    = 5'b11100;
  localparam logic [4:0] PEN_FETCH_STALL = 5'b11110;

  localparam logic [4:0] BUB_NONE        = 5'b00000;
  localparam logic [4:0] BUB_REDIRECT    = 5'b00110;
  localparam logic [4:0] BUB_LOAD_USE    = 5'b00100;
  localparam logic [4:0] BUB_FETCH_STALL = 5'b00010;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_TRAP,
    EV_MEM_STALL,
    EV_REDIRECT,
    EV_LOAD_USE,
    EV_FETCH_STALL
  } pipe_event_e;

  // An enabled stage takes its predecessor's valid unless it is bubbled;
  // fetch always produces a valid instruction when enabled.
  function automatic logic [4:0] advance_valid(input logic [4:0] valid,
                                               input logic [4:0] pen,
                                               input logic [4:0] bubble);
    logic [4:0] nxt;
    nxt = valid;
    for (int i = 1; i < 5; i++) begin
      if (pen[i]) nxt[i] = valid[i-1] & ~bubble[i];
    end
    if (pen[0]) nxt[0] = 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// pipe_hazard: load-use comparator between the execute-stage load and the
// decode-stage source registers.
// Ports:
//   ra1, ra2           decode source register addresses
//   ra1_zero, ra2_zero source is x0 (never a hazard)
//   rad, rad_zero      execute destination register, x0 flag
//   load               execute instruction is a load
//   valid_e, valid_d   execute / decode stage hold real instructions
//   hit                load-use hazard present
module pipe_hazard import pipe_pkg::*; #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  input  logic             ra1_zero,
  input  logic             ra2_zero,
  input  logic [REG_W-1:0] rad,
  input  logic             rad_zero,
  input  logic             load,
  input  logic             valid_e,
  input  logic             valid_d,
  output logic             hit
);

  logic match1;
  logic match2;

  assign match1 = (rad == ra1) & ~ra1_zero;
  assign match2 = (rad == ra2) & ~ra2_zero;
  assign hit    = valid_e & valid_d & load & ~rad_zero & (match1 | match2);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage enable / bubble controller for the rv32i 5-stage pipe
// (fetch, decode, execute, mem, commit).
// Ports:
//   clk, clr (async active-low reset)
//   imem_ready, dmem_req_m, dmem_ready       memory handshakes
//   ra1_d, ra2_d, ra1_zero_d, ra2_zero_d     decode sources
//   rad_e, rad_zero_e, load_e                execute destination / load flag
//   redirect_e, trap_c, restart              control-flow events
//   pen, bubble                              per-stage enable / nop insert
//   valid, halted, state                     status
// Optional: define PIPE_CTRL_PERF_EN to add perf_stall, perf_flush and
// perf_retire event counters (32-bit, wrapping).
module pipe_ctrl import pipe_pkg::*; #(
  parameter int NSTAGE = 5,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              imem_ready,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  input  logic [REG_W-1:0]  ra1_d,
  input  logic [REG_W-1:0]  ra2_d,
  input  logic              ra1_zero_d,
  input  logic              ra2_zero_d,
  input  logic [REG_W-1:0]  rad_e,
  input  logic              rad_zero_e,
  input  logic              load_e,
  input  logic              redirect_e,
  input  logic              trap_c,
  input  logic              restart,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush,
  output logic [31:0]       perf_retire,
`endif
  output logic [NSTAGE-1:0] pen,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] valid,
  output logic              halted,
  output logic [1:0]        state
);

  logic              load_use;
  logic              stall_mem;
  pipe_event_e       ev;
  logic [NSTAGE-1:0] pen_c;
  logic [NSTAGE-1:0] bub_c;
  logic [1:0]        state_nx;
  logic [NSTAGE-1:0] valid_nx;

  pipe_hazard #(.REG_W(REG_W)) u_hazard (
    .ra1      (ra1_d),
    .ra2      (ra2_d),
    .ra1_zero (ra1_zero_d),
    .ra2_zero (ra2_zero_d),
    .rad      (rad_e),
    .rad_zero (rad_zero_e),
    .load     (load_e),
    .valid_e  (valid[STG_E]),
    .valid_d  (valid[STG_D]),
    .hit      (load_use)
  );

  // Once in MEM_WAIT only dmem_ready matters; the mem-stage request that
  // caused the wait is frozen in place.
  always_comb begin
    stall_mem = (state == ST_MEM_WAIT) ? ~dmem_ready
                                       : (valid[STG_M] & dmem_req_m & ~dmem_ready);
    ev = EV_NONE;
    if ((state == ST_RUN) && valid[STG_C] && trap_c) ev = EV_TRAP;
    else if (stall_mem)                             ev = EV_MEM_STALL;
    else if (valid[STG_E] && redirect_e)            ev = EV_REDIRECT;
    else if (load_use)                              ev = EV_LOAD_USE;
    else if (!imem_ready)                           ev = EV_FETCH_STALL;
  end

  always_comb begin
    pen_c    = PEN_NONE;
    bub_c    = BUB_NONE;
    state_nx = state;
    valid_nx = valid;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        state_nx = ST_RUN;
        case (ev)
          EV_TRAP: begin
            pen_c    = PEN_TRAP;
            state_nx = ST_HALT;
          end
          EV_MEM_STALL:   state_nx = ST_MEM_WAIT;
          EV_REDIRECT: begin
            pen_c = PEN_ALL;
            bub_c = BUB_REDIRECT;
          end
          EV_LOAD_USE: begin
            pen_c = PEN_LOAD_USE;
            bub_c = BUB_LOAD_USE;
          end
          EV_FETCH_STALL: begin
            pen_c = PEN_FETCH_STALL;
            bub_c = BUB_FETCH_STALL;
          end
          default:        pen_c = PEN_ALL;
        endcase
        // The trapping instruction retires and everything behind it is
        // discarded, so the pipe empties completely.
        valid_nx = (ev == EV_TRAP) ? '0 : advance_valid(valid, pen_c, bub_c);
      end
      ST_HALT: begin
        if (restart) begin
          state_nx = ST_RUN;
          valid_nx = '0;
        end
      end
      default: begin
        state_nx = ST_RUN;
        valid_nx = '0;
      end
    endcase
  end

  assign pen    = clr ? pen_c : '0;
  assign bubble = clr ? bub_c : '0;
  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_RUN;
      valid <= '0;
    end else begin
      state <= state_nx;
      valid <= valid_nx;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      perf_stall  <= '0;
      perf_flush  <= '0;
      perf_retire <= '0;
    end else begin
      if ((state != ST_HALT) && (pen_c != PEN_ALL)) perf_stall <= perf_stall + 32'd1;
      if ((state != ST_HALT) && (ev == EV_REDIRECT)) perf_flush <= perf_flush + 32'd1;
      if (pen_c[STG_C] && valid[STG_C] && (ev != EV_TRAP))
        perf_retire <= perf_retire + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       imem_ready, dmem_req_m, dmem_ready;
  logic [4:0] ra1_d, ra2_d, rad_e;
  logic       ra1_zero_d, ra2_zero_d, rad_zero_e;
  logic       load_e, redirect_e, trap_c, restart;
  logic [4:0] pen, bubble, valid;
  logic       halted;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_retire;
  logic [31:0] m_stall, m_flush, m_retire;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(5), .REG_W(5)) dut (
    .clk(clk), .clr(clr),
    .imem_ready(imem_ready), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_zero_d(ra1_zero_d), .ra2_zero_d(ra2_zero_d),
    .rad_e(rad_e), .rad_zero_e(rad_zero_e), .load_e(load_e),
    .redirect_e(redirect_e), .trap_c(trap_c), .restart(restart),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_retire(perf_retire),
`endif
    .pen(pen), .bubble(bubble), .valid(valid), .halted(halted), .state(state)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: pipeline occupancy as a bit per stage, mode as an int.
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
  int         m_mode;
  logic [4:0] m_valid;
  logic [4:0] obs_pen, obs_bub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b1; dmem_req_m = 1'b0; dmem_ready = 1'b1;
    ra1_d = 5'd0; ra2_d = 5'd0; ra1_zero_d = 1'b1; ra2_zero_d = 1'b1;
    rad_e = 5'd0; rad_zero_e = 1'b1; load_e = 1'b0;
    redirect_e = 1'b0; trap_c = 1'b0; restart = 1'b0;
  endtask

  function automatic void predict(output logic [4:0] ep, output logic [4:0] eb,
                                  output int nm, output logic [4:0] nv,
                                  output bit redir, output bit trapped);
    bit hold;
    bit hazard;
    ep = 5'b0; eb = 5'b0; nm = m_mode; nv = m_valid; redir = 0; trapped = 0;
    if (m_mode == M_HALT) begin
      if (restart) begin nm = M_RUN; nv = 5'b0; end
      return;
    end
    if (m_mode == M_RUN && m_valid[4] && trap_c) begin
      ep = 5'b10000; nm = M_HALT; nv = 5'b0; trapped = 1;
      return;
    end
    if (m_mode == M_WAIT) hold = !dmem_ready;
    else                  hold = m_valid[3] && dmem_req_m && !dmem_ready;
    if (hold) begin nm = M_WAIT; return; end
    nm = M_RUN;
    hazard = m_valid[2] && m_valid[1] && load_e && !rad_zero_e &&
             ((rad_e == ra1_d && !ra1_zero_d) || (rad_e == ra2_d && !ra2_zero_d));
    if (m_valid[2] && redirect_e) begin ep = 5'b11111; eb = 5'b00110; redir = 1; end
    else if (hazard)              begin ep = 5'b11100; eb = 5'b00100; end
    else if (!imem_ready)         begin ep = 5'b11110; eb = 5'b00010; end
    else                                ep = 5'b11111;
    for (int i = 0; i < 5; i++)
      if (ep[i]) nv[i] = eb[i] ? 1'b0 : ((i == 0) ? 1'b1 : m_valid[i-1]);
  endfunction

  // Inputs are set just after a rising edge; outputs are checked 1 time unit
  // later and registered state 1 time unit after the following edge.
  task automatic cycle();
    logic [4:0] ep, eb, nv;
    int nm;
    bit redir, trapped;
    #1;
    predict(ep, eb, nm, nv, redir, trapped);
    obs_pen = pen;
    obs_bub = bubble;
    chk("pen", pen, ep);
    chk("bubble", bubble, eb);
`ifdef PIPE_CTRL_PERF_EN
    if (m_mode != M_HALT && ep != 5'b11111) m_stall++;
    if (redir) m_flush++;
    if (ep[4] && m_valid[4] && !trapped) m_retire++;
`endif
    @(posedge clk); #1;
    m_mode  = nm;
    m_valid = nv;
    chk("valid", valid, m_valid);
    chk("state", state, m_mode);
    chk("halted", halted, m_mode == M_HALT);
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_valid = 5'b0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall = 0; m_flush = 0; m_retire = 0;
`endif
  endtask

  initial begin
    logic [4:0] ramp;
    idle_inputs();
    model_reset();
    clr = 1'b0;

    // Reset state
    #3;
    chk("rst_pen", pen, 5'b0);
    chk("rst_bubble", bubble, 5'b0);
    chk("rst_valid", valid, 5'b0);
    chk("rst_state", state, 2'd0);
    chk("rst_halted", halted, 1'b0);
    @(posedge clk); #1; clr = 1'b1;

    // Fill ramp
    ramp = 5'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      ramp = {ramp[3:0], 1'b1};
      chk("ramp_valid", valid, ramp);
    end
    for (int k = 0; k < 5; k++) cycle();
    chk("full_pen", obs_pen, 5'b11111);

    // Load-use on ra1
    load_e = 1'b1; rad_e = 5'd5; rad_zero_e = 1'b0; ra1_d = 5'd5; ra1_zero_d = 1'b0;
    cycle();
    chk("lu_pen", obs_pen, 5'b11100);
    chk("lu_bubble", obs_bub, 5'b00100);
    chk("lu_valid2", valid[2], 1'b0);
    idle_inputs();
    for (int k = 0; k < 3; k++) cycle();
    // Same match against x0 destination: no stall
    load_e = 1'b1; rad_e = 5'd5; rad_zero_e = 1'b1; ra1_d = 5'd5; ra1_zero_d = 1'b0;
    cycle();
    chk("lu_x0_pen", obs_pen, 5'b11111);
    idle_inputs();

    // Redirect
    redirect_e = 1'b1;
    cycle();
    chk("redir_pen", obs_pen, 5'b11111);
    chk("redir_bubble", obs_bub, 5'b00110);
    chk("redir_valid21", valid[2:1], 2'b00);
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle();

    // Memory stall for three cycles, release on the fourth
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("mw_pen", obs_pen, 5'b0);
      chk("mw_state", state, 2'd1);
      chk("mw_valid", valid, 5'b11111);
    end
    dmem_ready = 1'b1;
    cycle();
    chk("mw_rel_pen", obs_pen, 5'b11111);
    chk("mw_rel_state", state, 2'd0);
    idle_inputs();

    // Trap, halt, restart
    trap_c = 1'b1;
    cycle();
    chk("trap_pen", obs_pen, 5'b10000);
    chk("trap_state", state, 2'd2);
    chk("trap_halted", halted, 1'b1);
    chk("trap_valid", valid, 5'b0);
    cycle();
    trap_c = 1'b0; restart = 1'b1;
    cycle();
    chk("restart_state", state, 2'd0);
    restart = 1'b0;
    cycle();
    chk("refill_valid", valid, 5'b00001);

    // Reset asserted in the middle of MEM_WAIT
    for (int k = 0; k < 4; k++) cycle();
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    cycle();
    chk("pre_clr_state", state, 2'd1);
    clr = 1'b0;
    #1;
    chk("clr_state", state, 2'd0);
    chk("clr_valid", valid, 5'b0);
    chk("clr_pen", pen, 5'b0);
    model_reset();
    @(posedge clk); #1; clr = 1'b1;
    idle_inputs();

    // Randomised traffic against the model
    for (int n = 0; n < 500; n++) begin
      imem_ready = ($urandom_range(0, 9) < 8);
      dmem_req_m = ($urandom_range(0, 9) < 3);
      dmem_ready = ($urandom_range(0, 9) < 6);
      ra1_d = 5'($urandom_range(0, 3)); ra1_zero_d = (ra1_d == 5'd0);
      ra2_d = 5'($urandom_range(0, 3)); ra2_zero_d = (ra2_d == 5'd0);
      rad_e = 5'($urandom_range(0, 3)); rad_zero_e = (rad_e == 5'd0);
      load_e = ($urandom_range(0, 9) < 3);
      redirect_e = ($urandom_range(0, 99) < 15);
      trap_c = ($urandom_range(0, 99) < 4);
      restart = ($urandom_range(0, 9) < 3);
      cycle();
    end

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_flush", perf_flush, m_flush);
    chk("perf_retire", perf_retire, m_retire);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline controller for the rv32i 5-stage pipe: fetch (p_0), decode (p_1), execute (p_2), mem (p_3), commit (p_4).
- Drives the per-stage register enables (pen) and bubble-inserts of the stage banks.
- Resolves memory stalls, load-use hazards, execute-stage redirects and commit-stage traps.
- Tracks per-stage valid bits so downstream stages ignore bubbles.

Parameters:
- NSTAGE, 5, number of stages. Fixed; other values are unsupported.
- REG_W, 5, register-address width.

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-low
- imem_ready  in  1  fetch data available this cycle
- dmem_req_m  in  1  mem-stage instruction is a load/store
- dmem_ready  in  1  data memory completes this cycle
- ra1_d  in  5  decode source reg 1
- ra2_d  in  5  decode source reg 2
- ra1_zero_d  in  1  ra1_d is x0
- ra2_zero_d  in  1  ra2_d is x0
- rad_e  in  5  execute destination reg
- rad_zero_e  in  1  rad_e is x0
- load_e  in  1  execute instruction is a load
- redirect_e  in  1  execute branch/jump taken (fetch must restart)
- trap_c  in  1  commit instruction is ecall/ebreak
- restart  in  1  leave HALT
- pen  out  5  bit i = stage i register enable
- bubble  out  5  bit i = stage i captures a nop (valid cleared); meaningful only with pen[i]
- valid  out  5  registered per-stage valid
- halted  out  1  state==HALT
- state  out  2  RUN=0, MEM_WAIT=1, HALT=2

Behaviour:
- Reset (clr low, async):
  - state=RUN; valid=0; halted=0.
  - pen and bubble are forced 0 while clr is low.
- pen/bubble are combinational from state, valid and the inputs. valid/state update on posedge clk.
- Priority in RUN, highest first:
  1. Trap: valid[4]&trap_c.
     - pen=5'b10000, bubble=0.
     - Next: HALT, valid[3:0]=0, valid[4]=0.
  2. Mem stall: valid[3]&dmem_req_m&!dmem_ready.
     - pen=0.
     - Next: MEM_WAIT.
  3. Redirect: valid[2]&redirect_e.
     - pen=5'b11111, bubble=5'b00110 (decode and execute receive nops).
     - Fetch restarts next cycle.
  4. Load-use: valid[2]&load_e&!rad_zero_e&((rad_e==ra1_d&!ra1_zero_d)|(rad_e==ra2_d&!ra2_zero_d))&valid[1].
     - pen=5'b11100, bubble=5'b00100.
  5. Fetch stall: !imem_ready.
     - pen=5'b11110, bubble=5'b00010.
  6. Otherwise: pen=5'b11111, bubble=0.
- MEM_WAIT:
  - pen=0 until dmem_ready.
  - The dmem_ready cycle evaluates the RUN rules as if in RUN, excluding mem stall, and the next state is RUN.
  - trap_c is ignored in MEM_WAIT; valid[4] is frozen.
- HALT:
  - pen=0, bubble=0, halted=1.
  - restart: next RUN with valid=0; fetch refills the pipe.
- Valid update per stage i≥1, when pen[i]: valid[i]<=valid[i-1]&!bubble[i]. pen[i]=0 holds.
- valid[0]<=1 whenever pen[0] in RUN.
- valid[4] with pen[4] and no stage-3 successor: valid[4]<=valid[3] (the commit result retires).
- Simultaneous events:
  - redirect wins over load-use and fetch stall.
  - A mem stall freezes a pending redirect; it resolves on the release cycle.
- Latency: redirect costs 2 bubbles; load-use costs 1 bubble.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs perf_stall[31:0] (cycles with pen!=5'b11111, not HALT), perf_flush[31:0] (redirects taken) and perf_retire[31:0] (cycles with pen[4]&valid[4]&!trap).
  - Counters wrap at 2^32. Reset to 0 by clr.
- Undefined: the counters and their ports are absent.

Decomposition:
- Shared package pipe_pkg: stage index constants (STG_F=0…STG_C=4), state encoding, pen/bubble pattern constants.
- Sub-module pipe_hazard: combinational load-use comparator. Outputs one bit.

Test Plan:
- Reset then 10 cycles, imem_ready=1, no events -> valid ramps 00001,00011,…,11111 by cycle 5; pen=11111.
- Execute load rad_e=5, decode ra1_d=5 -> one cycle pen=11100, bubble=00100; next cycle valid[2]=0. Same with rad_zero_e=1 -> no stall.
- redirect_e with valid[2]=1 -> pen=11111, bubble=00110; next cycle valid[2:1]=00.
- dmem_req_m=1, dmem_ready low 3 cycles -> state=MEM_WAIT, pen=0 for 3 cycles, valid unchanged; 4th cycle pen=11111, state RUN.
- trap_c with valid[4] -> next cycle state=HALT, halted=1, valid=0. restart -> RUN; valid rebuilds from 00001.
- clr asserted during MEM_WAIT -> immediate state=RUN, valid=0, pen=0.
